em_stage_skid: RTL

//  Parametrised EX/MEM pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/em_stage_skid.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/em_stage_skid.sv
// EX/MEM pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Optional perf counters (stall_cnt, flush_cnt) enabled by EM_PERF_CNT_EN.
module em_stage_skid #(
  parameter int DW = 32,
  parameter int AW = 5
`ifdef EM_PERF_CNT_EN
  ,
  parameter int CW = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wreg,
  input  logic          in_m2reg,
  input  logic          in_wmem,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_b,
  input  logic [AW-1:0] in_gpr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wreg,
  output logic          out_m2reg,
  output logic          out_wmem,
  output logic [DW-1:0] out_alu,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_gpr
`ifdef EM_PERF_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [DW-1:0] alu;
    logic [DW-1:0] b;
    logic [AW-1:0] gpr;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_nx;
  beat_t  in_beat, main_q, skid_q;
  logic   accept, drain;
  logic   ld_main_in, ld_main_skid, ld_skid;

  assign in_beat = '{
    wreg:  in_wreg,
    m2reg: in_m2reg,
    wmem:  in_wmem,
    alu:   in_alu,
    b:     in_b,
    gpr:   in_gpr
  };

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO);
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx   = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            state_nx = TWO;
            ld_skid  = 1'b1;
          end else if (drain) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nx     = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // Data regs only move on a load, so empty entries keep stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)   main_q <= in_beat;
      if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_beat;
    end
  end

  assign out_wreg  = out_valid && main_q.wreg;
  assign out_m2reg = out_valid && main_q.m2reg;
  assign out_wmem  = out_valid && main_q.wmem;
  assign out_alu   = main_q.alu;
  assign out_b     = main_q.b;
  assign out_gpr   = main_q.gpr;

`ifdef EM_PERF_CNT_EN
  logic [1:0]  occ;
  logic [CW:0] fsum;

  assign occ  = (state == TWO) ? 2'd2 :
                (state == ONE) ? 2'd1 : 2'd0;
  assign fsum = {1'b0, flush_cnt} + (CW+1)'(occ);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush)
        flush_cnt <= fsum[CW] ? '1 : fsum[CW-1:0];
    end
  end
`endif

endmodule
